class_hvec_sequencer: RTL
=========================

Name: class_hvec_sequencer

Overview:
- Sequences the combinational class-hypervector ROM (class_hvec_gen): drives its frame_id/frame_index address and registers the returned frame into a valid/ready stream for the similarity stage.
- Supports a full sweep of all classes × frames (class-major order) or a single-class fetch.
- Single output register; one beat per cycle when downstream is always ready.

Parameters:
- DI_PARALLEL_W_BITS, 64, width of one class-vector frame.
- NUM_CLASSES, 8, number of classes stored in the ROM.
- NUM_FRAMES, 3, frames per class vector.
- CLASS_ID_W, 3, width of class index (≥ clog2(NUM_CLASSES)).
- FRAME_ID_W, 2, width of frame index (≥ clog2(NUM_FRAMES)).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request a sequence; sampled only in IDLE.
- mode_single  in  1  1 = fetch only class_sel, 0 = full sweep; sampled with start.
- class_sel  in  CLASS_ID_W  class for single mode; sampled with start.
- abort  in  1  terminate the current sequence.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse after the final beat handshakes.
- start_err  out  1  one-cycle pulse when start is rejected.
- rom_frame_id  out  CLASS_ID_W  ROM class address.
- rom_frame_index  out  FRAME_ID_W  ROM frame address.
- rom_data  in  DI_PARALLEL_W_BITS  ROM output; combinational from the address.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accept.
- m_data  out  DI_PARALLEL_W_BITS  class-vector frame.
- m_class  out  CLASS_ID_W  class of the current beat.
- m_frame  out  FRAME_ID_W  frame of the current beat.
- m_last_frame  out  1  beat is frame NUM_FRAMES-1 of its class.
- m_last  out  1  final beat of the sequence.

Behaviour:
- Reset: every output is 0. The FSM enters IDLE and the counters clear.
- States: IDLE, RUN, DRAIN (enum in package).
- IDLE, start=1:
  - mode_single=1 and class_sel ≥ NUM_CLASSES → start_err pulses next cycle, stay IDLE.
  - Otherwise → RUN. Class counter = class_sel (single mode) or 0 (sweep). Frame counter = 0. End class = class_sel (single) or NUM_CLASSES-1 (sweep).
- Address outputs:
  - rom_frame_id/rom_frame_index equal the registered counters at all times.
  - They hold the last issued address in IDLE/DRAIN.
- Load condition (RUN only): load = !m_valid || m_ready. On load:
  - m_data ← rom_data; m_class/m_frame ← counters; m_valid ← 1.
  - m_last_frame ← (frame == NUM_FRAMES-1).
  - m_last ← (frame == NUM_FRAMES-1 && class == end class).
  - Counters advance: frame wraps NUM_FRAMES-1→0 and increments class.
- Loading the final beat → DRAIN. Counters do not advance past the end class.
- DRAIN, m_valid && m_ready → m_valid ← 0, done pulses for one cycle, → IDLE.
- In RUN, a beat that handshakes without a reload (not possible while in RUN, since load covers it) is excluded by design. m_valid drops only in DRAIN or on abort.
- Stall: while m_valid && !m_ready, m_data/m_class/m_frame/m_last* and the counters hold stable.
- Latency:
  - start sampled at edge E0 → first m_valid high after E1.
  - With m_ready held at 1: full sweep = NUM_CLASSES·NUM_FRAMES consecutive beats (24); single = NUM_FRAMES beats (3).
  - done pulses the cycle after the last handshake.
- Abort:
  - In RUN/DRAIN, abort wins over all other events. At the next edge m_valid ← 0 and the FSM goes to IDLE; no done pulse.
  - A beat handshaking in the same cycle as abort counts as delivered.
  - In IDLE, abort is ignored; simultaneous start is accepted.
- start while busy: ignored, no start_err.
- busy is registered: high from the cycle after start acceptance until the cycle done pulses (inclusive of DRAIN).
- Reset asserted mid-operation: immediate return to the reset values; no done pulse.

Decomposition:
- Package hdc_class_seq_pkg:
  - seq_state_t enum {IDLE, RUN, DRAIN}.
  - Default constants NUM_CLASSES=8, NUM_FRAMES=3, CLASS_ID_W, FRAME_ID_W.
- Sub-module class_frame_counter: nested frame/class counter with load-start, enable, wrap and is_last outputs. The FSM and output register stay in the top.
- The ROM stays outside the block (connected by the integrator) so ROM variants are swappable.

Test Plan:
- Full sweep, m_ready=1, ROM model returns {class,frame} pattern:
  - m_valid starts 2 cycles after start; 24 consecutive beats in order (0,0),(0,1),(0,2),(1,0)…(7,2).
  - m_last_frame on frames 2; m_last only on (7,2); done 1 cycle later; busy falls with done.
- Single mode, class_sel=5: exactly 3 beats (5,0),(5,1),(5,2); m_last on (5,2); done pulses once.
- Backpressure: toggle m_ready 1,0,0,1 pseudo-randomly during a sweep → no beat lost or duplicated, data stable while stalled, total 24 beats.
- Abort issued after the 10th handshake → m_valid 0 next cycle, no done, busy 0. A subsequent start runs a clean 24-beat sweep from (0,0).
- With NUM_CLASSES=6: single start with class_sel=7 → start_err pulse, busy stays 0. start while busy → ignored, sequence unaffected.
- Assert rst mid-sweep (beat 7) → all outputs 0 asynchronously. After release, idle until the next start.

Source files
------------

// File: rtl/hdc_class_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hdc_class_seq_pkg
// Brief    : Shared types and default geometry for the class-hypervector sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package hdc_class_seq_pkg;

    localparam int DEF_DI_PARALLEL_W_BITS = 64;
    localparam int DEF_NUM_CLASSES        = 8;
    localparam int DEF_NUM_FRAMES         = 3;
    localparam int DEF_CLASS_ID_W         = 3;
    localparam int DEF_FRAME_ID_W         = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/class_frame_counter.sv
`default_nettype none
// ============================================================================
// Module   : class_frame_counter
// Brief    : Nested frame/class address counter; saturates on the end class.
// Revision : 1.0 - initial release
// ============================================================================
module class_frame_counter
    import hdc_class_seq_pkg::*;
#(
    parameter int NUM_FRAMES = DEF_NUM_FRAMES,
    parameter int CLASS_ID_W = DEF_CLASS_ID_W,
    parameter int FRAME_ID_W = DEF_FRAME_ID_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [CLASS_ID_W-1:0] i_load_class,
    input  logic [CLASS_ID_W-1:0] i_load_end,
    input  logic                  i_enable,
    output logic [CLASS_ID_W-1:0] o_class,
    output logic [FRAME_ID_W-1:0] o_frame,
    output logic                  o_last_frame,
    output logic                  o_last
);

    localparam logic [FRAME_ID_W-1:0] c_last_frame = FRAME_ID_W'(NUM_FRAMES - 1);

    logic [CLASS_ID_W-1:0] r_class;
    logic [CLASS_ID_W-1:0] r_end;
    logic [FRAME_ID_W-1:0] r_frame;

    assign o_class      = r_class;
    assign o_frame      = r_frame;
    assign o_last_frame = (r_frame == c_last_frame);
    assign o_last       = o_last_frame && (r_class == r_end);

    // The final address is held so the ROM keeps presenting the last issued frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_class <= '0;
            r_end   <= '0;
            r_frame <= '0;
        end else if (i_load) begin
            r_class <= i_load_class;
            r_end   <= i_load_end;
            r_frame <= '0;
        end else if (i_enable && !o_last) begin
            if (o_last_frame) begin
                r_frame <= '0;
                r_class <= r_class + 1'b1;
            end else begin
                r_frame <= r_frame + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/class_hvec_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : class_hvec_sequencer
// Brief    : Walks the class-hypervector ROM and streams frames as valid/ready beats.
// Revision : 1.0 - initial release
// ============================================================================
module class_hvec_sequencer
    import hdc_class_seq_pkg::*;
#(
    parameter int DI_PARALLEL_W_BITS = DEF_DI_PARALLEL_W_BITS,
    parameter int NUM_CLASSES        = DEF_NUM_CLASSES,
    parameter int NUM_FRAMES         = DEF_NUM_FRAMES,
    parameter int CLASS_ID_W         = DEF_CLASS_ID_W,
    parameter int FRAME_ID_W         = DEF_FRAME_ID_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          mode_single,
    input  logic [CLASS_ID_W-1:0]         class_sel,
    input  logic                          abort,
    output logic                          busy,
    output logic                          done,
    output logic                          start_err,
    output logic [CLASS_ID_W-1:0]         rom_frame_id,
    output logic [FRAME_ID_W-1:0]         rom_frame_index,
    input  logic [DI_PARALLEL_W_BITS-1:0] rom_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DI_PARALLEL_W_BITS-1:0] m_data,
    output logic [CLASS_ID_W-1:0]         m_class,
    output logic [FRAME_ID_W-1:0]         m_frame,
    output logic                          m_last_frame,
    output logic                          m_last
);

    localparam logic [1:0] c_st_idle  = IDLE;
    localparam logic [1:0] c_st_run   = RUN;
    localparam logic [1:0] c_st_drain = DRAIN;

    localparam logic [CLASS_ID_W:0]   c_num_classes = (CLASS_ID_W + 1)'(NUM_CLASSES);
    localparam logic [CLASS_ID_W-1:0] c_sweep_end   = CLASS_ID_W'(NUM_CLASSES - 1);

    logic [1:0]                    r_state;
    logic                          r_busy;
    logic                          r_done;
    logic                          r_start_err;
    logic                          r_m_valid;
    logic [DI_PARALLEL_W_BITS-1:0] r_m_data;
    logic [CLASS_ID_W-1:0]         r_m_class;
    logic [FRAME_ID_W-1:0]         r_m_frame;
    logic                          r_m_last_frame;
    logic                          r_m_last;

    logic [CLASS_ID_W-1:0] w_cnt_class;
    logic [FRAME_ID_W-1:0] w_cnt_frame;
    logic                  w_cnt_last_frame;
    logic                  w_cnt_last;
    logic                  w_start_bad;
    logic                  w_accept;
    logic                  w_load;
    logic [CLASS_ID_W-1:0] w_load_class;
    logic [CLASS_ID_W-1:0] w_load_end;

    assign w_start_bad  = mode_single && ({1'b0, class_sel} >= c_num_classes);
    assign w_accept     = (r_state == c_st_idle) && start && !w_start_bad;
    // Abort outranks loading so no new beat is issued in the abort cycle.
    assign w_load       = (r_state == c_st_run) && !abort && (!r_m_valid || m_ready);
    assign w_load_class = mode_single ? class_sel : '0;
    assign w_load_end   = mode_single ? class_sel : c_sweep_end;

    class_frame_counter #(
        .NUM_FRAMES (NUM_FRAMES),
        .CLASS_ID_W (CLASS_ID_W),
        .FRAME_ID_W (FRAME_ID_W)
    ) u_counter (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_accept),
        .i_load_class (w_load_class),
        .i_load_end   (w_load_end),
        .i_enable     (w_load),
        .o_class      (w_cnt_class),
        .o_frame      (w_cnt_frame),
        .o_last_frame (w_cnt_last_frame),
        .o_last       (w_cnt_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= c_st_idle;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_start_err    <= 1'b0;
            r_m_valid      <= 1'b0;
            r_m_data       <= '0;
            r_m_class      <= '0;
            r_m_frame      <= '0;
            r_m_last_frame <= 1'b0;
            r_m_last       <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_start_err <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        if (w_start_bad) begin
                            r_start_err <= 1'b1;
                        end else begin
                            r_state <= c_st_run;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                c_st_run: begin
                    if (abort) begin
                        r_m_valid <= 1'b0;
                        r_state   <= c_st_idle;
                        r_busy    <= 1'b0;
                    end else if (w_load) begin
                        r_m_valid      <= 1'b1;
                        r_m_data       <= rom_data;
                        r_m_class      <= w_cnt_class;
                        r_m_frame      <= w_cnt_frame;
                        r_m_last_frame <= w_cnt_last_frame;
                        r_m_last       <= w_cnt_last;
                        if (w_cnt_last) begin
                            r_state <= c_st_drain;
                        end
                    end
                end
                c_st_drain: begin
                    if (abort) begin
                        r_m_valid <= 1'b0;
                        r_state   <= c_st_idle;
                        r_busy    <= 1'b0;
                    end else if (r_m_valid && m_ready) begin
                        r_m_valid <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= c_st_idle;
                        r_busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= c_st_idle;
                    r_busy    <= 1'b0;
                    r_m_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign start_err       = r_start_err;
    assign rom_frame_id    = w_cnt_class;
    assign rom_frame_index = w_cnt_frame;
    assign m_valid         = r_m_valid;
    assign m_data          = r_m_data;
    assign m_class         = r_m_class;
    assign m_frame         = r_m_frame;
    assign m_last_frame    = r_m_last_frame;
    assign m_last          = r_m_last;

endmodule
`default_nettype wire
